// File: rtl/imem_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream and writes
// little-endian 32-bit words into the instruction memory write port.
module imem_loader #(
  parameter int                   addrWidth  = 32,
  parameter int                   instrWidth = 32,
  parameter int                   depth      = 131072,
  parameter logic [addrWidth-1:0] baseAddr   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [addrWidth-1:0]  mem_addr,
  output logic [instrWidth-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERROR} state_t;

  localparam logic [31:0] maxWords = 32'(depth / 4);

  state_t         state, next_state;
  logic [1:0]     byte_cnt;
  logic [31:0]    len;
  logic [31:0]    word_idx;
  logic [23:0]    word_buf;
  logic           accept;
  logic           launch;
  logic           word_last;
  logic [31:0]    hdr_full;
  logic [addrWidth-1:0] word_off;

  assign accept    = in_valid && (state == HDR || state == DATA);
  assign launch    = start && (state == IDLE || state == DONE || state == ERROR);
  assign hdr_full  = {in_data, len[31:8]};
  assign word_last = (byte_cnt == 2'd3) && (word_idx == len - 32'd1);
  assign word_off  = addrWidth'({word_idx, 2'b00});

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = HDR;
      end
      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && byte_cnt == 2'd3) begin
          if (hdr_full == 32'd0)          next_state = DONE;
          else if (hdr_full > maxWords)   next_state = ERROR;
          else                            next_state = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && word_last) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) next_state = HDR;
      end
      ERROR: begin
        error = 1'b1;
        if (start) next_state = HDR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte counter wraps every 4 accepted bytes, so it tracks both header and word position.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt  <= 2'd0;
      len       <= 32'd0;
      word_idx  <= 32'd0;
      word_buf  <= 24'd0;
      mem_wen   <= 1'b0;
      mem_addr  <= baseAddr;
      mem_wdata <= '0;
    end else begin
      mem_wen <= 1'b0;
      if (launch) begin
        byte_cnt <= 2'd0;
        len      <= 32'd0;
        word_idx <= 32'd0;
        word_buf <= 24'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == HDR) begin
          len <= hdr_full;
        end else begin
          case (byte_cnt)
            2'd0: word_buf[7:0]   <= in_data;
            2'd1: word_buf[15:8]  <= in_data;
            2'd2: word_buf[23:16] <= in_data;
            default: begin
              mem_wen   <= 1'b1;
              mem_addr  <= baseAddr + word_off;
              mem_wdata <= {in_data, word_buf};
              word_idx  <= word_idx + 32'd1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level reference model predicts
// flags and memory writes every cycle; directed and random loads exercise it.
module tb_imem_loader;

  localparam int addrWidth = 32;
  localparam int depth     = 131072;
  localparam logic [31:0] maxWords = 32'(depth / 4);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  imem_loader #(
    .addrWidth (addrWidth),
    .instrWidth(32),
    .depth     (depth),
    .baseAddr  (32'h0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  bit          m_busy, m_done, m_err, m_wen;
  logic [31:0] m_addr, m_data, m_len, m_word;
  int          m_cnt;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted bytes of the stream; header then payload words.
  always @(posedge clock) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_err = 0; m_wen = 0;
      m_cnt = 0; m_len = 0; m_word = 0; m_addr = 0; m_data = 0;
    end else begin
      m_wen = 0;
      if (start && !m_busy) begin
        m_busy = 1; m_done = 0; m_err = 0; m_cnt = 0; m_len = 0;
      end else if (m_busy && in_valid) begin
        if (m_cnt < 4) begin
          m_len = m_len | (32'(in_data) << (8 * m_cnt));
          m_cnt++;
          if (m_cnt == 4) begin
            if (m_len == 0) begin m_busy = 0; m_done = 1; end
            else if (m_len > maxWords) begin m_busy = 0; m_err = 1; end
          end
        end else begin
          int k;
          k = m_cnt - 4;
          m_word[8 * (k % 4) +: 8] = in_data;
          m_cnt++;
          if (k % 4 == 3) begin
            m_wen  = 1;
            m_addr = 32'(4 * (k / 4));
            m_data = m_word;
            if (32'(k / 4) == m_len - 1) begin m_busy = 0; m_done = 1; end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, m_busy});
      checkOutput("busy",     {31'd0, busy},     {31'd0, m_busy});
      checkOutput("done",     {31'd0, done},     {31'd0, m_done});
      checkOutput("error",    {31'd0, error},    {31'd0, m_err});
      checkOutput("mem_wen",  {31'd0, mem_wen},  {31'd0, m_wen});
      if (mem_wen && m_wen) begin
        checkOutput("mem_addr",  mem_addr,  m_addr);
        checkOutput("mem_wdata", mem_wdata, m_data);
      end
      if (mem_wen) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
      end
    end
  end

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid plus stray starts
  task automatic applyStimulus(input logic [7:0] bytes[$], input int mode, input bit doStart);
    int i, cyc;
    bit v, acc;
    if (doStart) begin
      start = 1; @(posedge clock); #1; start = 0;
    end
    i = 0; cyc = 0;
    while (i < bytes.size()) begin
      case (mode)
        0:       v = 1;
        1:       v = (cyc % 2) == 1;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      in_valid = v;
      in_data  = v ? bytes[i] : 8'($urandom);
      if (mode == 2) start = ($urandom_range(0, 9) == 0);
      acc = v && in_ready;
      @(posedge clock); #1;
      if (acc) i++;
      cyc++;
      if (cyc > 2000) begin
        checkOutput("stream_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 0;
    start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    logic [7:0] q[$];
    repeat (2) @(posedge clock);
    #1;
    checking = 1;
    checkOutput("reset_addr",  mem_addr,  32'h0);
    checkOutput("reset_wdata", mem_wdata, 32'h0);
    checkOutput("reset_busy",  {31'd0, busy}, 32'd0);
    reset = 0;

    repeat (10) begin
      in_valid = 1'($urandom); in_data = 8'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 0;
    checkOutput("idle_no_write", 32'(log_addr.size()), 32'd0);

    for (int mode = 0; mode < 2; mode++) begin
      log_addr.delete(); log_data.delete();
      q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      applyStimulus(q, mode, 1);
      checkOutput("done_after_load", {31'd0, done}, 32'd1);
      idle(2);
      checkOutput("two_writes", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
        checkOutput("w0_addr", log_addr[0], 32'h0);
        checkOutput("w0_data", log_data[0], 32'h00000013);
        checkOutput("w1_addr", log_addr[1], 32'h4);
        checkOutput("w1_data", log_data[1], 32'h00100093);
      end
    end

    log_addr.delete(); log_data.delete();
    q = {8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(q, 0, 1);
    checkOutput("zero_len_done", {31'd0, done}, 32'd1);
    idle(2);
    checkOutput("zero_len_writes", 32'(log_addr.size()), 32'd0);

    q = {8'h01, 8'h80, 8'h00, 8'h00};
    applyStimulus(q, 0, 1);
    checkOutput("overflow_error", {31'd0, error}, 32'd1);
    checkOutput("overflow_ready", {31'd0, in_ready}, 32'd0);
    idle(2);
    checkOutput("overflow_writes", 32'(log_addr.size()), 32'd0);

    q = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    applyStimulus(q, 0, 1);
    reset = 1; @(posedge clock); #1; reset = 0;
    idle(2);
    checkOutput("partial_no_write", 32'(log_addr.size()), 32'd0);
    q = {8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(q, 0, 1);
    idle(2);
    checkOutput("fresh_writes", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      checkOutput("fresh_addr", log_addr[0], 32'h0);
      checkOutput("fresh_data", log_data[0], 32'hDEADBEEF);
    end

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(1, 8);
      log_addr.delete(); log_data.delete();
      q = {8'(n), 8'h00, 8'h00, 8'h00};
      for (int b = 0; b < 4 * n; b++) q.push_back(8'($urandom));
      applyStimulus(q, 2, 1);
      idle(2);
      checkOutput("rand_write_count", 32'(log_addr.size()), 32'(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
